// File: rtl/prbs31_chk_16.sv
// 16-bit parallel PRBS-31 (x^31 + x^28, XNOR) checker: self-syncs a predictor, then free-runs it.
// Optional LOSS_CNT output (count of lock losses) when PRBS_CHK_LOSS_CNT_EN is defined.
module prbs31_chk_16 #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 4,
  parameter int WINDOW     = 64,
  parameter int CNT_W      = 32
) (
  input  logic             C,
  input  logic             R_N,
  input  logic             CE,
  input  logic [15:0]      D,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR,
  output logic [4:0]       ERR_BITS,
  output logic [CNT_W-1:0] ERR_CNT
`ifdef PRBS_CHK_LOSS_CNT_EN
  ,
  output logic [7:0]       LOSS_CNT
`endif
);

  typedef enum logic [1:0] {ST_FILL, ST_HUNT, ST_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [30:0]      h_q, h_d;
  logic [1:0]       fill_q, fill_d;
  logic [7:0]       clean_q, clean_d;
  logic [15:0]      win_q, win_d;
  logic [15:0]      errw_q, errw_d;
  logic             err_q, err_d;
  logic [4:0]       err_bits_q, err_bits_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
`ifdef PRBS_CHK_LOSS_CNT_EN
  logic [7:0]       loss_q, loss_d;
`endif

  logic [15:0]      p, m;
  logic [4:0]       pop;
  logic [CNT_W:0]   sum;
  logic [15:0]      errw_inc;
  logic             wrap;

  // h_q[0] is the newest stream bit; every predicted bit reaches back 31/28 bits, all within H
  for (genvar j = 0; j < 16; j++) begin : g_pred
    assign p[15-j] = ~(h_q[30-j] ^ h_q[27-j]);
  end

  assign m = D ^ p;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 16; i++) pop = pop + {4'd0, m[i]};
  end

  assign sum      = {1'b0, err_cnt_q} + {{(CNT_W-4){1'b0}}, pop};
  assign errw_inc = errw_q + 16'd1;
  assign wrap     = (win_q == 16'(WINDOW - 1));

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    fill_d     = fill_q;
    clean_d    = clean_q;
    win_d      = win_q;
    errw_d     = errw_q;
    err_d      = 1'b0;
    err_bits_d = err_bits_q;
    err_cnt_d  = err_cnt_q;
`ifdef PRBS_CHK_LOSS_CNT_EN
    loss_d     = loss_q;
`endif
    if (CE) begin
      unique case (state_q)
        ST_FILL: begin
          h_d    = {h_q[14:0], D};
          fill_d = fill_q + 2'd1;
          if (fill_q == 2'd1) state_d = ST_HUNT;
        end
        ST_HUNT: begin
          h_d     = {h_q[14:0], D};
          clean_d = (m == 16'h0 && D != 16'hFFFF) ? clean_q + 8'd1 : 8'd0;
          if (clean_d == 8'(LOCK_CNT)) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            errw_d  = '0;
          end
        end
        default: begin
          // Free-run on the prediction so a flipped bit never reappears at the taps
          h_d        = {h_q[14:0], p};
          err_bits_d = pop;
          win_d      = wrap ? 16'd0 : win_q + 16'd1;
          if (m != 16'h0) begin
            err_d     = 1'b1;
            err_cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
          end
          if (m != 16'h0 && errw_inc >= 16'(UNLOCK_ERR)) begin
            state_d = ST_FILL;
            fill_d  = '0;
            clean_d = '0;
`ifdef PRBS_CHK_LOSS_CNT_EN
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
          end else if (wrap) begin
            errw_d = '0;
          end else if (m != 16'h0) begin
            errw_d = errw_inc;
          end
        end
      endcase
    end
    if (CLR_CNT) begin
      err_cnt_d = '0;
`ifdef PRBS_CHK_LOSS_CNT_EN
      loss_d    = '0;
`endif
    end
  end

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      state_q    <= ST_FILL;
      h_q        <= '0;
      fill_q     <= '0;
      clean_q    <= '0;
      win_q      <= '0;
      errw_q     <= '0;
      err_q      <= 1'b0;
      err_bits_q <= '0;
      err_cnt_q  <= '0;
`ifdef PRBS_CHK_LOSS_CNT_EN
      loss_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      fill_q     <= fill_d;
      clean_q    <= clean_d;
      win_q      <= win_d;
      errw_q     <= errw_d;
      err_q      <= err_d;
      err_bits_q <= err_bits_d;
      err_cnt_q  <= err_cnt_d;
`ifdef PRBS_CHK_LOSS_CNT_EN
      loss_q     <= loss_d;
`endif
    end
  end

  assign LOCKED   = (state_q == ST_LOCKED);
  assign ERR      = err_q;
  assign ERR_BITS = err_bits_q;
  assign ERR_CNT  = err_cnt_q;
`ifdef PRBS_CHK_LOSS_CNT_EN
  assign LOSS_CNT = loss_q;
`endif

endmodule

// File: tb/tb_prbs31_chk_16.sv
// Bench for prbs31_chk_16: random PRBS stream with planted errors, checked against a bit-level model.
module tb_prbs31_chk_16;
  localparam int CW = 8;
  localparam int LK = 8;
  localparam int UE = 4;
  localparam int WN = 64;

  logic          C = 1'b0;
  logic          R_N, CE, CLR_CNT;
  logic [15:0]   D;
  logic          LOCKED, ERR;
  logic [4:0]    ERR_BITS;
  logic [CW-1:0] ERR_CNT;
`ifdef PRBS_CHK_LOSS_CNT_EN
  logic [7:0]    LOSS_CNT;
`endif

  prbs31_chk_16 #(.LOCK_CNT(LK), .UNLOCK_ERR(UE), .WINDOW(WN), .CNT_W(CW)) dut (
    .C(C), .R_N(R_N), .CE(CE), .D(D), .CLR_CNT(CLR_CNT),
    .LOCKED(LOCKED), .ERR(ERR), .ERR_BITS(ERR_BITS), .ERR_CNT(ERR_CNT)
`ifdef PRBS_CHK_LOSS_CNT_EN
    , .LOSS_CNT(LOSS_CNT)
`endif
  );

  always #5 C = ~C;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // generator and model histories: oldest bit at index 0
  bit gq[$];
  bit hq[$];
  int ms;            // 0 fill, 1 hunt, 2 locked
  int m_fill, m_clean, m_win, m_errw, m_cnt, m_bits, m_loss;
  bit m_err;

  task automatic gen_word(output logic [15:0] w);
    bit b;
    for (int j = 0; j < 16; j++) begin
      b = ~(gq[0] ^ gq[3]);
      gq.push_back(b);
      void'(gq.pop_front());
      w[15-j] = b;
    end
  endtask

  task automatic model_reset();
    hq.delete();
    for (int i = 0; i < 31; i++) hq.push_back(1'b0);
    ms = 0; m_fill = 0; m_clean = 0; m_win = 0; m_errw = 0;
    m_cnt = 0; m_bits = 0; m_loss = 0; m_err = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int j = 0; j < 16; j++) begin
      hq.push_back(w[15-j]);
      void'(hq.pop_front());
    end
  endtask

  task automatic model_accept(input bit ce, input logic [15:0] d, input bit clr);
    bit t[47];
    logic [15:0] pw, mm;
    int pc;
    m_err = 1'b0;
    if (ce) begin
      for (int i = 0; i < 31; i++) t[i] = hq[i];
      for (int j = 0; j < 16; j++) begin
        t[31+j] = ~(t[j] ^ t[j+3]);
        pw[15-j] = t[31+j];
      end
      mm = d ^ pw;
      pc = $countones(mm);
      if (ms == 0) begin
        push_word(d);
        m_fill++;
        if (m_fill == 2) ms = 1;
      end else if (ms == 1) begin
        push_word(d);
        if (mm == 16'h0 && d != 16'hFFFF) m_clean++; else m_clean = 0;
        if (m_clean == LK) begin ms = 2; m_win = 0; m_errw = 0; end
      end else begin
        push_word(pw);
        m_bits = pc;
        if (pc > 0) begin
          m_err = 1'b1;
          m_cnt = (m_cnt + pc > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + pc;
          m_errw++;
        end
        if (m_errw >= UE) begin
          ms = 0; m_fill = 0; m_clean = 0;
          if (m_loss < 255) m_loss++;
        end else if (m_win == WN - 1) begin
          m_errw = 0;
        end
        m_win = (m_win + 1) % WN;
      end
    end
    if (clr) begin m_cnt = 0; m_loss = 0; end
  endtask

  task automatic step(input bit ce, input logic [15:0] d, input bit clr);
    @(negedge C);
    CE = ce; D = d; CLR_CNT = clr;
    @(posedge C);
    model_accept(ce, d, clr);
    #1;
    chk("locked", LOCKED, (ms == 2));
    chk("err", ERR, m_err);
    if (m_err) chk("err_bits", ERR_BITS, m_bits);
    chk("err_cnt", ERR_CNT, m_cnt);
`ifdef PRBS_CHK_LOSS_CNT_EN
    chk("loss_cnt", LOSS_CNT, m_loss);
`endif
  endtask

  task automatic send(input bit ce, input logic [15:0] flip, input bit clr);
    logic [15:0] w;
    if (ce) begin gen_word(w); w = w ^ flip; end
    else w = 16'($urandom);
    step(ce, w, clr);
  endtask

  // feeds clean words until LOCKED, returns accepted-word count (bounded)
  task automatic lock_wait(input bit rand_ce, output int n);
    int iter;
    bit ce;
    n = 0; iter = 0;
    while (!LOCKED && iter < 100) begin
      ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
      send(ce, 16'h0, 1'b0);
      if (ce) n++;
      iter++;
    end
  endtask

  int n;
  int lock_seen;
  int pos[6] = '{5, 30, 55, 70, 95, 120};
  logic [15:0] fl;

  initial begin
    R_N = 1'b0; CE = 1'b0; D = '0; CLR_CNT = 1'b0;
    for (int i = 0; i < 31; i++) gq.push_back(1'($urandom));
    gq[0] = 1'b0;
    model_reset();
    repeat (2) @(posedge C);
    #1;
    chk("rst_locked", LOCKED, 0);
    chk("rst_err", ERR, 0);
    chk("rst_bits", ERR_BITS, 0);
    chk("rst_cnt", ERR_CNT, 0);
    @(negedge C);
    R_N = 1'b1;

    // clean stream: lock after 2 fill + LOCK_CNT clean words
    lock_wait(1'b0, n);
    chk("lock_first", n, 2 + LK);
    repeat (190) send(1'b1, 16'h0, 1'b0);
    chk("clean_cnt", ERR_CNT, 0);

    // single-bit error, no follow-on errors
    send(1'b1, 16'h0001, 1'b0);
    chk("one_err", ERR, 1);
    chk("one_bits", ERR_BITS, 1);
    chk("one_cnt", ERR_CNT, 1);
    repeat (40) send(1'b1, 16'h0, 1'b0);
    chk("one_after", ERR_CNT, 1);

    // four full-word errors force unlock
    send(1'b0, 16'h0, 1'b1);
    repeat (4) send(1'b1, 16'hFFFF, 1'b0);
    chk("unl_cnt", ERR_CNT, 64);
    chk("unl_locked", LOCKED, 0);
    lock_wait(1'b0, n);
    chk("relock", n, 2 + LK);

    // 3 errors in one window and 3 in the next keep lock
    send(1'b0, 16'h0, 1'b1);
    for (int i = 0; i <= 120; i++) begin
      fl = 16'h0;
      for (int k = 0; k < 6; k++) if (pos[k] == i) fl = 16'h0007;
      send(1'b1, fl, 1'b0);
    end
    chk("win_locked", LOCKED, 1);
    chk("win_cnt", ERR_CNT, 18);

    // lock-up pattern never locks
    R_N = 1'b0;
    model_reset();
    #2;
    R_N = 1'b1;
    lock_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 16'hFFFF, 1'b0);
      if (LOCKED) lock_seen = 1;
    end
    chk("ffff_nolock", lock_seen, 0);
    lock_wait(1'b1, n);
    chk("lock_ce50", n, 2 + LK);

    // saturation, then clear coincident with an error
    for (int e = 0; e < 20; e++) begin
      repeat (21) send(1'b1, 16'h0, 1'b0);
      send(1'b1, 16'hFFFF, 1'b0);
    end
    chk("sat_cnt", ERR_CNT, (1 << CW) - 1);
    repeat (21) send(1'b1, 16'h0, 1'b0);
    send(1'b1, 16'hFFFF, 1'b1);
    chk("clr_err", ERR, 1);
    chk("clr_cnt", ERR_CNT, 0);

    // asynchronous reset between edges
    repeat (20) send(1'b1, 16'h0, 1'b0);
    send(1'b1, 16'h0003, 1'b0);
    @(posedge C);
    #3;
    R_N = 1'b0;
    #1;
    chk("arst_locked", LOCKED, 0);
    chk("arst_err", ERR, 0);
    chk("arst_bits", ERR_BITS, 0);
    chk("arst_cnt", ERR_CNT, 0);
    model_reset();
    @(negedge C);
    R_N = 1'b1;
    lock_wait(1'b0, n);
    chk("arst_relock", n, 2 + LK);

`ifdef PRBS_CHK_LOSS_CNT_EN
    send(1'b0, 16'h0, 1'b1);
    for (int u = 0; u < 3; u++) begin
      repeat (4) send(1'b1, 16'hFFFF, 1'b0);
      chk("loss_unl", LOCKED, 0);
      lock_wait(1'b0, n);
    end
    chk("loss_3", LOSS_CNT, 3);
    send(1'b0, 16'h0, 1'b1);
    chk("loss_clr", LOSS_CNT, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
